// File: rtl/reqsend_pkg.sv
// Shared types and width helpers for the toggle-handshake requester.
package reqsend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reqsend_if.sv
// Local write port plus the req/ack/data toggle link of the requester.
interface reqsend_if
  import reqsend_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int CW = cnt_width(DEPTH);

  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             full;
  logic [CW-1:0]    count;
  logic             busy;
  logic             req;
  logic [WIDTH-1:0] data;
  logic             ack;

  // master: the requester block itself
  modport master (
    input  we, wdata, ack,
    output full, count, busy, req, data
  );

  // slave: local writer plus the remote acknowledging domain
  modport slave (
    output we, wdata, ack,
    input  full, count, busy, req, data
  );

endinterface

// File: rtl/reqsend_sync_sr.sv
// Two-flop synchronizer, synchronous active-high reset to zero; 2-cycle latency.
module sync_sr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reqsend.sv
// Queued toggle requester: write-to-req flip in 3 cycles, one transfer outstanding;
// writes are dropped while full, the link waits indefinitely on the remote ack.
module reqsend
  import reqsend_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  reqsend_if.master bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_q;
  logic             req_q;
  logic             ack_s;
  logic             push;
  logic             pop;
  logic             flip;
  state_t           state;
  state_t           state_nxt;

  sync_sr #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ack),
    .q     (ack_s)
  );

  // A full queue refuses the write outright, regardless of a same-cycle pop.
  assign push = bus.we && (cnt != FULL_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ack_s == req means nothing is outstanding; that also holds off a
  // launch after a local-only reset until the remote side catches up.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flip      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((ack_s == req_q) && (cnt != '0)) begin
          pop       = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        flip      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_s == req_q) begin
          if (cnt != '0) begin
            pop       = 1'b1;
            state_nxt = ST_SETUP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      req_q  <= 1'b0;
    end else begin
      if (pop) begin
        data_q <= mem[rd_ptr];
      end
      if (flip) begin
        req_q <= ~req_q;
      end
    end
  end

  assign bus.full  = (cnt == FULL_CNT);
  assign bus.count = cnt;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.req   = req_q;
  assign bus.data  = data_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt <= FULL_CNT);

  a_data_hold: assert property (@(posedge clk) disable iff (reset)
    (state == ST_WAIT && ack_s != req_q) |=> $stable(data_q));

endmodule
